// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART transmitter (and future receiver).
package uart_pkg;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_EVEN = 2'd1,
        PARITY_ODD  = 2'd2
    } parity_mode_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic IDLE_BIT  = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Clocks per line bit; the remainder of the division is deliberately dropped.
    function automatic int unsigned uart_cycles(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..UART_CYCLES-1, restartable by clear, flags the last clock of each bit.
module uart_baud_gen #(
    parameter int UART_CYCLES = 868
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic end_of_bit
);

    localparam int CW = ($clog2(UART_CYCLES) > 1) ? $clog2(UART_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(UART_CYCLES - 1);

    logic [CW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || end_of_bit) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign end_of_bit = (count == LAST);

endmodule

// File: rtl/uart_tx_cfg.sv
// AXI-Stream to UART transmitter with parameterised data width, parity and stop bits.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned  CLOCK_FREQ_HZ = 100_000_000,
    parameter int unsigned  BAUD_RATE     = 115_200,
    parameter int           DATA_BITS     = 8,
    parameter parity_mode_t PARITY        = PARITY_NONE,
    parameter int           STOP_BITS     = 1
) (
    input  logic                 s_axis_aclk,
    input  logic                 s_axis_aresetn,
    input  logic                 s_axis_tvalid,
    input  logic [DATA_BITS-1:0] s_axis_tdata,
    output logic                 s_axis_tready,
    output logic                 tx_bit,
    output logic                 tx_busy
);

    localparam int UART_CYCLES = int'(uart_cycles(CLOCK_FREQ_HZ, BAUD_RATE));
    localparam int BIT_W       = ($clog2(DATA_BITS) > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    if (UART_CYCLES < 2) begin : g_bad_baud
        $error("uart_tx_cfg: CLOCK_FREQ_HZ / BAUD_RATE must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_cfg: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end

    tx_state_t            state, state_next;
    logic [BIT_W-1:0]     bit_cnt;
    logic                 stop_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 parity_r;
    logic                 end_of_bit;
    logic                 xfer;

    assign s_axis_tready = s_axis_aresetn &&
                           (state == IDLE || (state == STOP && end_of_bit && stop_cnt == LAST_STOP));
    assign xfer    = s_axis_tvalid && s_axis_tready;
    assign tx_busy = (state != IDLE);

    uart_baud_gen #(.UART_CYCLES(UART_CYCLES)) u_baud (
        .clk        (s_axis_aclk),
        .rst_n      (s_axis_aresetn),
        .clear      (xfer),
        .end_of_bit (end_of_bit)
    );

    // NOTE: defaults first so every path assigns state_next and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:             if (xfer) state_next = START;
            START:            if (end_of_bit) state_next = DATA;
            DATA:             if (end_of_bit && bit_cnt == LAST_BIT)
                                  state_next = (PARITY != PARITY_NONE) ? uart_pkg::PARITY : STOP;
            uart_pkg::PARITY: if (end_of_bit) state_next = STOP;
            STOP:             if (end_of_bit && stop_cnt == LAST_STOP)
                                  state_next = xfer ? START : IDLE;
            default:          state_next = IDLE;
        endcase
    end

    // NOTE: the shift register is reset too, so the line decode never sees X after reset.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            shift    <= '0;
            parity_r <= 1'b0;
        end else begin
            state <= state_next;
            if (xfer) begin
                shift    <= s_axis_tdata;
                parity_r <= (PARITY == PARITY_ODD) ? ~^s_axis_tdata : ^s_axis_tdata;
            end else if (state == DATA && end_of_bit) begin
                shift <= shift >> 1;
            end
            if (state == START && end_of_bit) begin
                bit_cnt <= '0;
            end else if (state == DATA && end_of_bit && bit_cnt != LAST_BIT) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            // Entry into STOP from DATA or PARITY restarts the stop-bit count.
            if (state != STOP && state_next == STOP) begin
                stop_cnt <= 1'b0;
            end else if (state == STOP && end_of_bit && stop_cnt != LAST_STOP) begin
                stop_cnt <= stop_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        tx_bit = IDLE_BIT;
        case (state)
            IDLE:             tx_bit = IDLE_BIT;
            START:            tx_bit = START_BIT;
            DATA:             tx_bit = shift[0];
            uart_pkg::PARITY: tx_bit = parity_r;
            STOP:             tx_bit = STOP_BIT;
            default:          tx_bit = IDLE_BIT;
        endcase
    end

endmodule
